delay_sched: RTL and testbench

- Two-channel scheduler that shares one pulse generator between two delay-line timestamp FIFOs.
- Each FIFO holds release timestamps of the form "counter value + delay". The scheduler compares each FIFO head with the free-running timestamp counter.
- For each due entry, it pops the entry and fires one trigger to the pulse generator.
- It holds off further triggers while a pulse is being generated, arbitrates round-robin when both heads are due, and discards entries that are too late to honour.

---
 rtl/delay_sched.sv | 132 +++++++++++++
 tb/tb_delay_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sched.sv
// Two-channel delay-line scheduler: pops due timestamps from two FWFT FIFOs and
// shares one pulse generator between them with round-robin arbitration.
//
// state | meaning
// IDLE  | evaluating FIFO heads every cycle while en=1
// HOLD  | pulse generator busy, no pops or triggers
module delay_sched #(
    parameter int CTR_WIDTH         = 18,
    parameter int PULSE_BUSY_CYCLES = 130,
    parameter int LATE_WINDOW       = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CTR_WIDTH-1:0] ctr,
    input  logic                 ch0_empty,
    input  logic [CTR_WIDTH-1:0] ch0_data,
    output logic                 ch0_rden,
    input  logic                 ch1_empty,
    input  logic [CTR_WIDTH-1:0] ch1_data,
    output logic                 ch1_rden,
    output logic                 trig,
    output logic                 trig_ch,
    output logic                 busy,
    input  logic                 clr_cnt,
    output logic [15:0]          drop_cnt
);

    localparam int HW = (PULSE_BUSY_CYCLES > 2) ? $clog2(PULSE_BUSY_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(PULSE_BUSY_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] LATE_LIM = CTR_WIDTH'(LATE_WINDOW);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            rr_ptr, rr_nxt;
    logic            rden0_nxt, rden1_nxt, trig_nxt, trig_ch_nxt, busy_nxt;
    logic [15:0]     drop_nxt;
    logic [1:0]      drops;
    logic [16:0]     drop_sum;
    logic            go, win;

    logic [CTR_WIDTH-1:0] diff0, diff1;
    logic due0, due1, late0, late1, ok0, ok1;

    // A channel whose rden is high this cycle is masked: its head is still the popped word.
    assign diff0 = ctr - ch0_data;
    assign diff1 = ctr - ch1_data;
    assign due0  = !ch0_empty && !ch0_rden && !diff0[CTR_WIDTH-1];
    assign due1  = !ch1_empty && !ch1_rden && !diff1[CTR_WIDTH-1];
    assign late0 = due0 && (diff0 > LATE_LIM);
    assign late1 = due1 && (diff1 > LATE_LIM);
    assign ok0   = due0 && !late0;
    assign ok1   = due1 && !late1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rr_ptr   <= 1'b0;
            ch0_rden <= 1'b0;
            ch1_rden <= 1'b0;
            trig     <= 1'b0;
            trig_ch  <= 1'b0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            rr_ptr   <= rr_nxt;
            ch0_rden <= rden0_nxt;
            ch1_rden <= rden1_nxt;
            trig     <= trig_nxt;
            trig_ch  <= trig_ch_nxt;
            busy     <= busy_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        rr_nxt      = rr_ptr;
        rden0_nxt   = 1'b0;
        rden1_nxt   = 1'b0;
        trig_nxt    = 1'b0;
        trig_ch_nxt = trig_ch;
        drops       = 2'd0;
        go          = 1'b0;
        win         = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    rden0_nxt = late0;
                    rden1_nxt = late1;
                    drops     = 2'(late0) + 2'(late1);
                    if (ok0 && ok1) begin
                        go  = 1'b1;
                        win = rr_ptr;
                    end else if (ok0 || ok1) begin
                        go  = 1'b1;
                        win = ok1;
                    end
                    if (go) begin
                        rr_nxt      = ~win;
                        trig_nxt    = 1'b1;
                        trig_ch_nxt = win;
                        state_nxt   = HOLD;
                        hold_nxt    = HOLD_LOAD;
                        if (win) rden1_nxt = 1'b1;
                        else     rden0_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Terminal count at zero keeps busy high for exactly PULSE_BUSY_CYCLES cycles.
                if (hold_cnt == '0) state_nxt = IDLE;
                else                hold_nxt  = hold_cnt - HW'(1);
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == HOLD);
        drop_sum = 17'(drop_cnt) + 17'(drops);
        if (clr_cnt)          drop_nxt = '0;
        else if (drop_sum[16]) drop_nxt = 16'hFFFF;
        else                  drop_nxt = drop_sum[15:0];
    end

endmodule

// File: tb/tb_delay_sched.sv
// Randomized and directed bench for delay_sched against a timestamp-level reference model.
module tb_delay_sched;
    localparam int W   = 18;
    localparam int PBC = 130;
    localparam int LW  = 64;
    localparam int MOD = 1 << W;

    logic clk = 1'b0;
    logic rst, en, clr_cnt;
    logic [W-1:0] ctr, ch0_data, ch1_data;
    logic ch0_empty, ch1_empty, ch0_rden, ch1_rden;
    logic trig, trig_ch, busy;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    delay_sched #(.CTR_WIDTH(W), .PULSE_BUSY_CYCLES(PBC), .LATE_WINDOW(LW)) dut (
        .clk(clk), .rst(rst), .en(en), .ctr(ctr),
        .ch0_empty(ch0_empty), .ch0_data(ch0_data), .ch0_rden(ch0_rden),
        .ch1_empty(ch1_empty), .ch1_data(ch1_data), .ch1_rden(ch1_rden),
        .trig(trig), .trig_ch(trig_ch), .busy(busy),
        .clr_cnt(clr_cnt), .drop_cnt(drop_cnt)
    );

    int checks = 0, failures = 0;
    int q0[$], q1[$];
    int ctr_v;
    bit en_v, clr_v;

    // Reference model: remembers when the last trigger happened instead of tracking a state.
    bit e_rden0, e_rden1, e_trig, e_trig_ch, e_busy, m_ptr;
    int e_drop;
    longint cyc = 0, m_last_trig;

    int n_trig, first_trig_ctr, first_trig_ch, busy_run, last_busy_len, act_cycles;
    bit sim_seen;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        e_rden0 = 0; e_rden1 = 0; e_trig = 0; e_trig_ch = 0; e_busy = 0;
        e_drop = 0; m_ptr = 0; m_last_trig = -1000000;
    endfunction

    function automatic int diff_of(int head);
        return (ctr_v - head) & (MOD - 1);
    endfunction

    function automatic void model_eval();
        int d0, d1, nd;
        bit due0, due1, late0, late1, ok0, ok1, go, win, r0, r1, t;
        nd = 0; go = 0; win = 0; r0 = 0; r1 = 0; t = 0;
        if (en_v && (cyc - m_last_trig >= PBC)) begin
            d0 = (q0.size() > 0) ? diff_of(q0[0]) : 0;
            d1 = (q1.size() > 0) ? diff_of(q1[0]) : 0;
            due0 = (q0.size() > 0) && !e_rden0 && (d0 < MOD / 2);
            due1 = (q1.size() > 0) && !e_rden1 && (d1 < MOD / 2);
            late0 = due0 && (d0 > LW);
            late1 = due1 && (d1 > LW);
            ok0 = due0 && !late0;
            ok1 = due1 && !late1;
            r0 = late0; r1 = late1;
            nd = int'(late0) + int'(late1);
            if (ok0 && ok1) begin go = 1; win = m_ptr; end
            else if (ok0)   begin go = 1; win = 0; end
            else if (ok1)   begin go = 1; win = 1; end
            if (go) begin
                m_ptr = !win;
                m_last_trig = cyc + 1;
                t = 1;
                e_trig_ch = win;
                if (win) r1 = 1; else r0 = 1;
            end
        end
        e_rden0 = r0; e_rden1 = r1; e_trig = t;
        e_busy = (cyc + 1 - m_last_trig) < PBC;
        if (clr_v) e_drop = 0;
        else e_drop = (e_drop + nd > 65535) ? 65535 : e_drop + nd;
    endfunction

    function automatic void drive_inputs();
        ctr = W'(ctr_v);
        ch0_empty = (q0.size() == 0);
        ch1_empty = (q1.size() == 0);
        ch0_data = (q0.size() > 0) ? W'(q0[0]) : '0;
        ch1_data = (q1.size() > 0) ? W'(q1[0]) : '0;
        en = en_v;
        clr_cnt = clr_v;
    endfunction

    function automatic void clear_records();
        n_trig = 0; first_trig_ctr = -1; first_trig_ch = -1; busy_run = 0;
        last_busy_len = 0; act_cycles = 0; sim_seen = 0;
    endfunction

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        check("rden0", ch0_rden, e_rden0);
        check("rden1", ch1_rden, e_rden1);
        check("trig", trig, e_trig);
        check("trig_ch", trig_ch, e_trig_ch);
        check("busy", busy, e_busy);
        check("drop_cnt", drop_cnt, e_drop);
        if (e_rden0 && q0.size() > 0) void'(q0.pop_front());
        if (e_rden1 && q1.size() > 0) void'(q1.pop_front());
        ctr_v = (ctr_v + 1) & (MOD - 1);
        drive_inputs();
        if (trig) begin
            n_trig++;
            if (n_trig == 1) begin first_trig_ctr = ctr_v; first_trig_ch = int'(trig_ch); end
        end
        if (trig && ch0_rden && ch1_rden) sim_seen = 1;
        if (trig || ch0_rden || ch1_rden) act_cycles++;
        if (busy) busy_run++;
        else if (busy_run > 0) begin last_busy_len = busy_run; busy_run = 0; end
        model_eval();
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rden0", ch0_rden, 0);
        check("rst_rden1", ch1_rden, 0);
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        q0.delete(); q1.delete();
        en_v = 1; clr_v = 0;
        model_reset();
        clear_records();
        rst = 0;
        drive_inputs();
        model_eval();
    endtask

    initial begin
        rst = 1; ctr_v = 0; en_v = 1; clr_v = 0;
        model_reset();
        drive_inputs();
        do_reset();

        // single entry
        ctr_v = 989; q0.push_back(1000);
        repeat (200) step();
        check("single_ntrig", n_trig, 1);
        check("single_trig_ctr", first_trig_ctr, 1001);
        check("single_trig_ch", first_trig_ch, 0);
        check("single_busy_len", last_busy_len, 130);
        check("single_drop", drop_cnt, 0);

        // arbitration: loser goes late during the hold
        do_reset();
        ctr_v = 489; q0.push_back(500); q1.push_back(500);
        repeat (300) step();
        check("arb_ntrig", n_trig, 1);
        check("arb_trig_ctr", first_trig_ctr, 501);
        check("arb_trig_ch", first_trig_ch, 0);
        check("arb_drop", drop_cnt, 1);

        // counter wrap
        do_reset();
        ctr_v = 262139; q0.push_back(5);
        repeat (30) step();
        check("wrap_ntrig", n_trig, 1);
        check("wrap_trig_ctr", first_trig_ctr, 6);
        check("wrap_drop", drop_cnt, 0);

        // drop and fire together
        do_reset();
        ctr_v = 309; q0.push_back(100); q1.push_back(300);
        repeat (20) step();
        check("sim_seen", sim_seen, 1);
        check("sim_trig_ch", first_trig_ch, 1);
        check("sim_drop", drop_cnt, 1);

        // en gating and clr_cnt
        do_reset();
        en_v = 0; ctr_v = 1999; q0.push_back(1000); q1.push_back(1500);
        repeat (1000) step();
        check("en_off_activity", act_cycles, 0);
        en_v = 1;
        repeat (5) step();
        check("en_on_drop", drop_cnt, 2);
        clr_v = 1; step(); clr_v = 0; step();
        check("clr_drop", drop_cnt, 0);

        // saturation
        do_reset();
        ctr_v = 5000;
        for (int i = 0; i < 65700; i++) begin
            while (q0.size() < 2) q0.push_back((ctr_v - 100) & (MOD - 1));
            while (q1.size() < 2) q1.push_back((ctr_v - 100) & (MOD - 1));
            step();
        end
        check("sat_drop", drop_cnt, 16'hFFFF);

        // randomized traffic across a wrap
        do_reset();
        ctr_v = MOD - 2000;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 4)
                q0.push_back((ctr_v + int'($urandom_range(0, 400)) - 150) & (MOD - 1));
            if ($urandom_range(0, 3) == 0 && q1.size() < 4)
                q1.push_back((ctr_v + int'($urandom_range(0, 400)) - 150) & (MOD - 1));
            if ($urandom_range(0, 299) == 0) en_v = !en_v;
            clr_v = ($urandom_range(0, 199) == 0);
            step();
        end
        clr_v = 0; en_v = 1;

        // reset in the middle of a hold
        do_reset();
        ctr_v = 999; q0.push_back(990); q1.push_back(800);
        repeat (52) step();
        check("mid_busy_before", busy, 1);
        check("mid_drop_before", drop_cnt, 1);
        #2 rst = 1;
        #1;
        check("mid_async_busy", busy, 0);
        check("mid_async_trig", trig, 0);
        check("mid_async_rden", {ch0_rden, ch1_rden}, 0);
        check("mid_async_drop", drop_cnt, 0);
        do_reset();
        ctr_v = 1999; q0.push_back(1990); q1.push_back(1990);
        repeat (10) step();
        check("mid_after_ntrig", n_trig, 1);
        check("mid_after_trig_ch", first_trig_ch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
